// File: rtl/vga_pixel_timing_gen.sv
// vga_pixel_timing_gen: 800x525 raster timing generator with fixed-latency
// pixel fetch and aligned HDMI-side outputs (sync, vde, drawX/drawY, RGB).
// Optional build macro VGA_TEST_PATTERN_EN adds a test_mode input that
// replaces the fetched colour with eight 80-pixel vertical colour bars.
module vga_pixel_timing_gen #(
    parameter int H_ACTIVE  = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_ACTIVE  = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int FETCH_LAT = 2
) (
    input  logic        pixel_clk,
    input  logic        arstn,
    input  logic        enable,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [9:0]  fetch_x,
    output logic [9:0]  fetch_y,
    output logic        fetch_valid,
    input  logic [23:0] fetch_rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        vde,
    output logic [9:0]  drawX,
    output logic [9:0]  drawY,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        frame_start,
    output logic        line_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST_C   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST_C   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_ACT_C    = 10'(H_ACTIVE);
    localparam logic [9:0] V_ACT_C    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_BEG_C   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END_C   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_BEG_C   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END_C   = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // One delay-line slot: everything that must stay aligned with the colour.
    typedef struct packed {
        logic       hs;
        logic       vs;
        logic       vde;
        logic       fs;
        logic       ls;
        logic [9:0] x;
        logic [9:0] y;
    } stage_t;

    localparam stage_t BLANK_C = '{hs: 1'b1, vs: 1'b1, vde: 1'b0, fs: 1'b0,
                                   ls: 1'b0, x: 10'd0, y: 10'd0};

`ifdef VGA_TEST_PATTERN_EN
    function automatic logic [23:0] bar_colour(input logic [9:0] x);
        if (x < 10'd80)       return 24'hFFFFFF;
        else if (x < 10'd160) return 24'hFFFF00;
        else if (x < 10'd240) return 24'h00FFFF;
        else if (x < 10'd320) return 24'h00FF00;
        else if (x < 10'd400) return 24'hFF00FF;
        else if (x < 10'd480) return 24'hFF0000;
        else if (x < 10'd560) return 24'h0000FF;
        else                  return 24'h000000;
    endfunction
`endif

    state_t      state_q, state_d;
    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic        active_s;
    logic        line_end_s;
    logic        frame_end_s;
    logic        visible_s;
    stage_t      stage0_s;
    stage_t      dl_q [FETCH_LAT];
    stage_t      last_s;
    logic [23:0] rgb_d;

    stage_t      out_q;
    logic [23:0] rgb_q;

    assign line_end_s  = (hc_q == H_LAST_C);
    assign frame_end_s = line_end_s && (vc_q == V_LAST_C);
    assign visible_s   = (hc_q < H_ACT_C) && (vc_q < V_ACT_C);

    // FSM state register
    always_ff @(posedge pixel_clk) begin
        if (!arstn) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next state: a dropped enable only ends the run at the frame wrap
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
                else        state_d = ST_IDLE;
            end
            ST_RUN, ST_DRAIN: begin
                if (enable)           state_d = ST_RUN;
                else if (frame_end_s) state_d = ST_IDLE;
                else                  state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: counters advance in RUN and DRAIN
    always_comb begin
        active_s = 1'b0;
        case (state_q)
            ST_RUN:   active_s = 1'b1;
            ST_DRAIN: active_s = 1'b1;
            ST_IDLE:  active_s = 1'b0;
            default:  active_s = 1'b0;
        endcase
    end

    // Raster counter next value; held at the origin while idle
    always_comb begin
        hc_d = hc_q;
        vc_d = vc_q;
        if (active_s) begin
            if (line_end_s) begin
                hc_d = 10'd0;
                if (vc_q == V_LAST_C) vc_d = 10'd0;
                else                  vc_d = vc_q + 10'd1;
            end else begin
                hc_d = hc_q + 10'd1;
                vc_d = vc_q;
            end
        end else begin
            hc_d = 10'd0;
            vc_d = 10'd0;
        end
    end

    // Raster counter registers
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            hc_q <= 10'd0;
            vc_q <= 10'd0;
        end else begin
            hc_q <= hc_d;
            vc_q <= vc_d;
        end
    end

    assign fetch_x = hc_q;
    assign fetch_y = vc_q;
`ifdef VGA_TEST_PATTERN_EN
    assign fetch_valid = active_s && visible_s && !test_mode;
`else
    assign fetch_valid = active_s && visible_s;
`endif

    // Stage-0 sync/enable terms; idle feeds the blank pattern into the pipe
    always_comb begin
        stage0_s = BLANK_C;
        if (active_s) begin
            stage0_s.hs  = !((hc_q >= HS_BEG_C) && (hc_q < HS_END_C));
            stage0_s.vs  = !((vc_q >= VS_BEG_C) && (vc_q < VS_END_C));
            stage0_s.vde = visible_s;
            stage0_s.fs  = (hc_q == 10'd0) && (vc_q == 10'd0);
            stage0_s.ls  = (hc_q == 10'd0);
            stage0_s.x   = hc_q;
            stage0_s.y   = vc_q;
        end else begin
            stage0_s = BLANK_C;
        end
    end

    // Delay line matching the draw-logic read latency
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            for (int i = 0; i < FETCH_LAT; i++) dl_q[i] <= BLANK_C;
        end else begin
            dl_q[0] <= stage0_s;
            for (int i = 1; i < FETCH_LAT; i++) dl_q[i] <= dl_q[i-1];
        end
    end

    assign last_s = dl_q[FETCH_LAT-1];

    // Colour select: returned data only counts inside the visible region
    always_comb begin
        rgb_d = 24'h000000;
        if (last_s.vde) begin
`ifdef VGA_TEST_PATTERN_EN
            if (test_mode) rgb_d = bar_colour(last_s.x);
            else           rgb_d = fetch_rgb;
`else
            rgb_d = fetch_rgb;
`endif
        end else begin
            rgb_d = 24'h000000;
        end
    end

    // Output registers: timing and colour leave together
    always_ff @(posedge pixel_clk) begin
        if (!arstn) begin
            out_q <= BLANK_C;
            rgb_q <= 24'h000000;
        end else begin
            out_q <= last_s;
            rgb_q <= rgb_d;
        end
    end

    assign hsync       = out_q.hs;
    assign vsync       = out_q.vs;
    assign vde         = out_q.vde;
    assign drawX       = out_q.x;
    assign drawY       = out_q.y;
    assign frame_start = out_q.fs;
    assign line_start  = out_q.ls;
    assign red         = rgb_q[23:16];
    assign green       = rgb_q[15:8];
    assign blue        = rgb_q[7:0];

endmodule

// File: doc/vga_pixel_timing_gen.md
# vga_pixel_timing_gen

Video timing generator and pixel-stream transmitter for the HDMI path. It produces the 800×525 raster (640×480 visible) as pixel-clock-rate coordinates and issues a fixed-latency fetch to the pixel/tile draw logic. It then emits hsync, vsync, vde, drawX, drawY and red/green/blue, all mutually aligned, to the HDMI encoder. These are the signals the frame-capture bench samples to rebuild each frame image.

## Interface
Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, hsync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch
- FETCH_LAT, 2, draw-logic read latency in cycles; legal range 1..8

Ports:
- pixel_clk  in  1  pixel clock (25 MHz)
- arstn  in  1  reset, synchronous, active-low
- enable  in  1  run request
- fetch_x  out  10  raster X of the pixel being requested
- fetch_y  out  10  raster Y of the pixel being requested
- fetch_valid  out  1  request is for a visible pixel
- fetch_rgb  in  24  {R,G,B} returned exactly FETCH_LAT cycles after the request
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- vde  out  1  video data enable (visible region)
- drawX  out  10  raster X aligned to RGB, range 0..799
- drawY  out  10  raster Y aligned to RGB, range 0..524
- red, green, blue  out  8 each  pixel colour
- frame_start  out  1  one-cycle pulse with the output pixel (0,0)
- line_start  out  1  one-cycle pulse with every output pixel X=0

## Operation
- Raw counters hc (0..H_TOTAL−1) and vc (0..V_TOTAL−1). H_TOTAL = 800 and V_TOTAL = 525 with the defaults.
- hc increments every enabled cycle. When hc wraps to 0, vc increments. vc wraps to 0 after V_TOTAL−1.
- Stage 0 drives these signals combinationally from the counters:
  - fetch_x = hc, fetch_y = vc.
  - fetch_valid = (hc < H_ACTIVE) && (vc < V_ACTIVE).
- Stage-0 sync and enable terms:
  - hs0 is low for H_ACTIVE+H_FP ≤ hc < H_ACTIVE+H_FP+H_SYNC, i.e. hc 656..751.
  - vs0 is low for vc 490..491.
  - vde0 = fetch_valid.
- hs0, vs0, vde0, hc, vc and the frame/line-start flags pass through a FETCH_LAT-deep register delay line.
- The output registers capture the last delay stage together with the colour:
  - red/green/blue = fetch_rgb when the delayed vde is 1, else 0.
- States:
  - IDLE: counters held at (0,0); delay-line inputs forced to the blank value (hs=1, vs=1, vde=0, start flags 0).
  - RUN: counters advance.
  - DRAIN: counters advance; exit when the frame completes.
- Transitions:
  - IDLE→RUN when enable=1. Counting starts on the next cycle, from (0,0).
  - RUN→DRAIN when enable=0.
  - DRAIN→RUN when enable returns to 1.
  - DRAIN→IDLE when the counters wrap from (799,524) to (0,0).
- A frame is therefore never truncated by enable.

## Timing
- Output latency: FETCH_LAT+1 cycles from a counter value to the matching drawX/drawY/RGB.
- The output order is contiguous. Every output cycle is either a raster pixel or the IDLE blank pattern; no gaps or duplicates are allowed.
- Line = 800 cycles; frame = 420 000 cycles.
- Each line has 640 vde-high cycles, then 16 blank, then 96 with hsync low, then 48 blank.
- vsync is low for exactly 1600 consecutive cycles per frame. It rises at the output pixel (0,492).
- Reset values, asserted on the cycle after the clock edge that samples arstn=0:
  - hsync=1, vsync=1, vde=0.
  - drawX=0, drawY=0.
  - RGB=0.
  - frame_start=0, line_start=0.
  - Delay line cleared to blank; state=IDLE.
- Reset mid-frame aborts the frame immediately with no drain.
- Simultaneous enable fall and frame wrap: the block goes to IDLE with no extra frame.
- fetch_rgb is ignored when the delayed vde is 0.

## Configuration
- Macro VGA_TEST_PATTERN_EN.
- When defined:
  - Adds input port test_mode (1 bit).
  - With test_mode=1, RGB is replaced by 8 vertical bars, 80 px each, from drawX/80. Order: FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000.
  - With test_mode=1, fetch_valid is forced to 0.
  - Timing and latency are unchanged.
- When undefined: no test_mode port, and RGB always comes from fetch_rgb.

## Test plan
- Hold arstn=0 for 4 cycles → hsync=1, vsync=1, vde=0, RGB=0, drawX=drawY=0, no pulses.
- Set enable=1 with FETCH_LAT=2 and a source returning {x[7:0], y[7:0], 8'h5A}.
  - Expect drawX/drawY to match the returned colour at every vde pixel.
  - Expect vde high for exactly 640×480 = 307 200 cycles per frame.
- Count cycles across one full frame:
  - hsync low is 96 cycles, starting at drawX=656.
  - vsync low is 1600 cycles, drawY 490..491.
  - frame_start pulses every 420 000 cycles.
- Drop enable at drawY=100 → the frame completes through (799,524), then outputs hold the blank pattern. Raising enable again → frame_start after exactly FETCH_LAT+2 cycles.
- Assert arstn=0 at drawY=300 for one cycle → the next cycle shows the reset values. After re-enable, the raster restarts at (0,0).
- With VGA_TEST_PATTERN_EN defined and test_mode=1:
  - drawX=85 gives RGB FFFF00.
  - drawX=639 gives 000000.
  - fetch_valid stays 0.
